ram_cmd_arbiter: RTL
====================

# ram_cmd_arbiter

Two-requester controller that shares the single-port 256x8 command-driven RAM between two internal masters, e.g. the SPI slave path and a local debug/host port. Each write or read request is translated into the RAM's two-word 10-bit command sequence: address word, then data or read word. The arbiter waits for the RAM's read-valid and returns a one-cycle acknowledge to the owner. Arbitration between the two requesters is round-robin.

## Interface
- ADDR_SIZE, 8: address and data field width; RAM command word is ADDR_SIZE+2 bits.
- TIMEOUT_CYCLES, 15: read-wait watchdog limit in cycles (used only with the timeout feature).

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  request; held high until the matching ack.
- we0 / we1  in  1  1 = write, 0 = read; sampled with req.
- addr0 / addr1  in  ADDR_SIZE  target address.
- wdata0 / wdata1  in  ADDR_SIZE  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- gnt  out  2  one-hot current owner; held from acceptance through the DONE cycle.
- rdata  out  ADDR_SIZE  read data; valid while ack is high and held until the next read completes.
- err  out  1  timeout flag; pulses together with ack.
- ram_din  out  ADDR_SIZE+2  command word to the RAM.
- ram_rx_valid  out  1  command strobe to the RAM.
- ram_dout  in  ADDR_SIZE  RAM read data.
- ram_tx_valid  in  1  RAM read-valid.

## Operation
- FSM states: IDLE, ADDR, DATA, WAIT, DONE.
- IDLE:
  - If any req is high, select the owner, latch we/addr/wdata, set gnt, and go to ADDR.
  - Round-robin: if both requesters are high, grant the one not served last. The last-served pointer resets to 1, so req0 wins the first tie.
- ADDR: ram_rx_valid=1; ram_din={2'b00,addr} for a write or {2'b10,addr} for a read; go to DATA.
- DATA: ram_rx_valid=1; ram_din={2'b01,wdata} for a write (next state DONE) or {2'b11,0} for a read (next state WAIT).
- WAIT: on ram_tx_valid=1, capture rdata<=ram_dout and go to DONE. The RAM clears tx_valid on the address word, so a stale high value is not possible here.
- DONE:
  - Assert ack for the owner.
  - Update the last-served pointer.
  - Clear gnt at the next edge and return to IDLE.
- ram_rx_valid and ram_din are decoded from registered state only; there is no combinational path from req inputs to RAM pins. Outside ADDR/DATA, ram_rx_valid=0 and ram_din=0.
- Requests are sampled only in IDLE. A non-owner req held during a transaction is served next. A req still high in the cycle after DONE is treated as a new request.
- Reset values: state IDLE, gnt=0, ack0=ack1=0, err=0, rdata=0, ram_rx_valid=0, ram_din=0, pointer=1, timeout counter=0.
- Reset asserted mid-transaction aborts it immediately with no ack. Any partial RAM address is left as-is and is harmless.

## Timing
- Acceptance edge = the edge at which IDLE sees req. Cycles below count from that edge.
- Write: ADDR in cycle 1, DATA in cycle 2, ack in cycle 3. Minimum period is 4 cycles including the return to IDLE.
- Read: ADDR 1, DATA 2, WAIT 3 (ram_tx_valid is seen high here on a normal RAM), ack with rdata in cycle 4. Period is 5 cycles.
- Back-to-back requests from alternating requesters lose no cycles beyond the single IDLE cycle.

## Configuration
- RAM_ARB_TIMEOUT_EN defined:
  - WAIT counts cycles.
  - After TIMEOUT_CYCLES cycles without ram_tx_valid, go to DONE with ack=1, err=1, rdata=0.
  - The counter clears on entry to WAIT.
- RAM_ARB_TIMEOUT_EN undefined: WAIT blocks indefinitely, err is tied to 0, and no counter is built.

## Test plan
- Reset: pulse rst mid-read -> all outputs 0 and state IDLE within the same cycle; no ack; the next request proceeds normally.
- req0 write addr=8'h3C data=8'hA5, then req0 read addr=8'h3C:
  - RAM sees 10'h03C, then 10'h1A5, then 10'h23C, then 10'h300.
  - ack0 in cycle 3 for the write and cycle 4 for the read; rdata=8'hA5.
- req0 and req1 both reads, asserted the same cycle from reset -> req0 served first, then req1 with no idle gap beyond one cycle; gnt=2'b01 then 2'b10.
- Both requesters continuously requesting writes for 6 transactions -> grants strictly alternate 0,1,0,1,0,1.
- With RAM_ARB_TIMEOUT_EN, RAM model holds tx_valid=0 -> ack1 and err pulse exactly 15 cycles after WAIT entry; rdata=8'h00; a following write completes normally.
- Write addr=8'hFF data=8'h00, then read addr=8'h00 (boundary addresses) -> correct command words and rdata reflects the prior contents of address 0.

Source files
------------

// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter that turns two requesters' read/write requests into the RAM's
// two-word command sequence. Optional read-wait watchdog: define RAM_ARB_TIMEOUT_EN.
module ram_cmd_arbiter #(
    parameter int ADDR_SIZE      = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [ADDR_SIZE-1:0] addr1,
    input  logic [ADDR_SIZE-1:0] wdata0,
    input  logic [ADDR_SIZE-1:0] wdata1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [1:0]           gnt,
    output logic [ADDR_SIZE-1:0] rdata,
    output logic                 err,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT, DONE} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   owner;
    logic                   last;
    logic                   sel;
    logic                   tmo_hit;
    logic                   we_q;
    logic [ADDR_SIZE-1:0]   addr_q;
    logic [ADDR_SIZE-1:0]   wdata_q;

    // On a tie the requester that was not served last wins.
    assign sel = (req0 && req1) ? ~last : req1;
    assign gnt = (state == IDLE) ? 2'b00 : {owner, ~owner};

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             tmo_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            tmo_flag <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (state == IDLE)
                tmo_flag <= 1'b0;
            else if (state == WAIT)
                tmo_flag <= tmo_hit;
        end
    end

    assign tmo_hit = (state == WAIT) && !ram_tx_valid &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err     = (state == DONE) && tmo_flag;
`else
    // No watchdog in this build: WAIT holds until the RAM answers.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= 1'b0;
            last  <= 1'b1;
            rdata <= '0;
        end else begin
            if (state == IDLE && (req0 || req1))
                owner <= sel;
            if (state == DONE)
                last <= owner;
            if (state == WAIT) begin
                if (ram_tx_valid)
                    rdata <= ram_dout;
                else if (tmo_hit)
                    rdata <= '0;
            end
        end
    end

    // Request fields are only meaningful once a grant is taken, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            we_q    <= sel ? we1    : we0;
            addr_q  <= sel ? addr1  : addr0;
            wdata_q <= sel ? wdata1 : wdata0;
        end
    end

    always_comb begin
        state_nxt    = state;
        ram_rx_valid = 1'b0;
        ram_din      = '0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        case (state)
            IDLE: if (req0 || req1) state_nxt = ADDR;
            ADDR: begin
                ram_rx_valid = 1'b1;
                ram_din      = {~we_q, 1'b0, addr_q};
                state_nxt    = DATA;
            end
            DATA: begin
                ram_rx_valid = 1'b1;
                ram_din      = we_q ? {2'b01, wdata_q} : {2'b11, {ADDR_SIZE{1'b0}}};
                state_nxt    = we_q ? DONE : WAIT;
            end
            WAIT: if (ram_tx_valid || tmo_hit) state_nxt = DONE;
            DONE: begin
                ack0      = ~owner;
                ack1      = owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
